// File: rtl/board_update_ctrl_if.sv
// Board update controller bus: move requests and status in from game logic,
// single write port out to the 64x4 board array.
//   new_game, move_req, move_from, move_to, move_piece : game logic -> controller
//   wr_en, wr_addr, wr_piece                           : controller -> board array
//   busy, move_ack, move_reject, turn, move_count      : controller -> game logic
interface board_update_ctrl_if #(
    parameter int unsigned COUNT_WIDTH = 8
);
    logic                   new_game;
    logic                   move_req;
    logic [5:0]             move_from;
    logic [5:0]             move_to;
    logic [3:0]             move_piece;
    logic                   wr_en;
    logic [5:0]             wr_addr;
    logic [3:0]             wr_piece;
    logic                   busy;
    logic                   move_ack;
    logic                   move_reject;
    logic                   turn;
    logic [COUNT_WIDTH-1:0] move_count;

    // Game-logic side
    modport master (
        output new_game, move_req, move_from, move_to, move_piece,
        input  wr_en, wr_addr, wr_piece, busy, move_ack, move_reject, turn, move_count
    );

    // Controller side
    modport slave (
        input  new_game, move_req, move_from, move_to, move_piece,
        output wr_en, wr_addr, wr_piece, busy, move_ack, move_reject, turn, move_count
    );
endinterface

// File: rtl/board_update_ctrl.sv
// Sequencer owning the single write port of the 64x4 board register.
// Loads the opening position (one square per cycle) after reset or NEW_GAME,
// then executes validated moves as a destination write followed by a source
// clear, with turn tracking, pawn promotion and a saturating move counter.
// Ports:
//   i_clk    game-logic clock, rising edge
//   i_rst_n  asynchronous active-low reset (RESET)
//   io_bus   request/status/board-write bundle (slave side)
module board_update_ctrl #(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned PROMOTE_EN  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    board_update_ctrl_if.slave  io_bus
);

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned PIECE_W = 4;
    localparam int unsigned TYPE_W  = 3;

    localparam logic [TYPE_W-1:0] P_NONE   = 3'b000;
    localparam logic [TYPE_W-1:0] P_PAWN   = 3'b001;
    localparam logic [TYPE_W-1:0] P_KNIGHT = 3'b010;
    localparam logic [TYPE_W-1:0] P_BISHOP = 3'b011;
    localparam logic [TYPE_W-1:0] P_ROOK   = 3'b100;
    localparam logic [TYPE_W-1:0] P_QUEEN  = 3'b101;
    localparam logic [TYPE_W-1:0] P_KING   = 3'b110;

    localparam logic [ADDR_W-1:0] LAST_SQ = 6'd63;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WR_DST = 2'd2,
        ST_WR_SRC = 2'd3
    } state_t;

    state_t                 r_state,     w_state_nxt;
    logic [ADDR_W-1:0]      r_load_cnt,  w_load_cnt_nxt;
    logic [ADDR_W-1:0]      r_from,      w_from_nxt;
    logic [ADDR_W-1:0]      r_to,        w_to_nxt;
    logic [PIECE_W-1:0]     r_piece,     w_piece_nxt;
    logic                   r_wr_en,     w_wr_en_nxt;
    logic [ADDR_W-1:0]      r_wr_addr,   w_wr_addr_nxt;
    logic [PIECE_W-1:0]     r_wr_piece,  w_wr_piece_nxt;
    logic                   r_busy,      w_busy_nxt;
    logic                   r_ack,       w_ack_nxt;
    logic                   r_reject,    w_reject_nxt;
    logic                   r_turn,      w_turn_nxt;
    logic [COUNT_WIDTH-1:0] r_count,     w_count_nxt;
    logic                   r_done_pend, w_done_pend_nxt;
    logic                   w_turn_eff;
    logic                   w_req_ok;

    // Opening position: black back rank on row 0, white back rank on row 7
    function automatic logic [PIECE_W-1:0] f_opening(input logic [ADDR_W-1:0] addr);
        logic [TYPE_W-1:0]  back;
        logic [PIECE_W-1:0] pc;
        case (addr[2:0])
            3'd0, 3'd7: back = P_ROOK;
            3'd1, 3'd6: back = P_KNIGHT;
            3'd2, 3'd5: back = P_BISHOP;
            3'd3:       back = P_QUEEN;
            default:    back = P_KING;
        endcase
        case (addr[5:3])
            3'd0:    pc = {1'b1, back};
            3'd1:    pc = {1'b1, P_PAWN};
            3'd6:    pc = {1'b0, P_PAWN};
            3'd7:    pc = {1'b0, back};
            default: pc = '0;
        endcase
        return pc;
    endfunction

    // Piece written to the destination, queening pawns on the far rank
    function automatic logic [PIECE_W-1:0] f_dst_piece(input logic [ADDR_W-1:0]  to,
                                                        input logic [PIECE_W-1:0] pc);
        logic far_rank;
        far_rank = pc[3] ? (to[5:3] == 3'd7) : (to[5:3] == 3'd0);
        if ((PROMOTE_EN != 0) && (pc[2:0] == P_PAWN) && far_rank) begin
            return {pc[3], P_QUEEN};
        end
        return pc;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_load_cnt_nxt  = r_load_cnt;
        w_from_nxt      = r_from;
        w_to_nxt        = r_to;
        w_piece_nxt     = r_piece;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_piece_nxt  = r_wr_piece;
        w_busy_nxt      = r_busy;
        w_ack_nxt       = 1'b0;
        w_reject_nxt    = 1'b0;
        w_turn_nxt      = r_turn;
        w_count_nxt     = r_count;
        w_done_pend_nxt = 1'b0;

        // A move finishing on this edge already hands the turn over, so a
        // request arriving on the same edge is checked against the new side.
        w_turn_eff = r_done_pend ? ~r_turn : r_turn;
        w_req_ok   = (io_bus.move_from != io_bus.move_to)
                  && (io_bus.move_piece[2:0] != P_NONE)
                  && (io_bus.move_piece[3] == w_turn_eff);

        if (io_bus.new_game) begin
            // Restart load; any in-flight move and pending ack are dropped
            w_state_nxt    = ST_INIT;
            w_load_cnt_nxt = '0;
            w_busy_nxt     = 1'b1;
            w_turn_nxt     = 1'b0;
            w_count_nxt    = '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_wr_en_nxt    = 1'b1;
                    w_wr_addr_nxt  = r_load_cnt;
                    w_wr_piece_nxt = f_opening(r_load_cnt);
                    w_busy_nxt     = 1'b1;
                    w_load_cnt_nxt = r_load_cnt + ADDR_W'(1);
                    w_reject_nxt   = io_bus.move_req;
                    if (r_load_cnt == LAST_SQ) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    w_busy_nxt = 1'b0;
                    if (r_done_pend) begin
                        w_ack_nxt  = 1'b1;
                        w_turn_nxt = ~r_turn;
                        if (r_count != {COUNT_WIDTH{1'b1}}) begin
                            w_count_nxt = r_count + COUNT_WIDTH'(1);
                        end
                    end
                    if (io_bus.move_req) begin
                        if (w_req_ok) begin
                            w_from_nxt  = io_bus.move_from;
                            w_to_nxt    = io_bus.move_to;
                            w_piece_nxt = io_bus.move_piece;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = ST_WR_DST;
                        end else begin
                            w_reject_nxt = 1'b1;
                        end
                    end
                end
                ST_WR_DST: begin
                    w_wr_en_nxt    = 1'b1;
                    w_wr_addr_nxt  = r_to;
                    w_wr_piece_nxt = f_dst_piece(r_to, r_piece);
                    w_busy_nxt     = 1'b1;
                    w_reject_nxt   = io_bus.move_req;
                    w_state_nxt    = ST_WR_SRC;
                end
                ST_WR_SRC: begin
                    w_wr_en_nxt     = 1'b1;
                    w_wr_addr_nxt   = r_from;
                    w_wr_piece_nxt  = '0;
                    w_busy_nxt      = 1'b1;
                    w_reject_nxt    = io_bus.move_req;
                    w_done_pend_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_INIT;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_INIT;
            r_load_cnt  <= '0;
            r_from      <= '0;
            r_to        <= '0;
            r_piece     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_piece  <= '0;
            r_busy      <= 1'b1;
            r_ack       <= 1'b0;
            r_reject    <= 1'b0;
            r_turn      <= 1'b0;
            r_count     <= '0;
            r_done_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_cnt  <= w_load_cnt_nxt;
            r_from      <= w_from_nxt;
            r_to        <= w_to_nxt;
            r_piece     <= w_piece_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_piece  <= w_wr_piece_nxt;
            r_busy      <= w_busy_nxt;
            r_ack       <= w_ack_nxt;
            r_reject    <= w_reject_nxt;
            r_turn      <= w_turn_nxt;
            r_count     <= w_count_nxt;
            r_done_pend <= w_done_pend_nxt;
        end
    end

    assign io_bus.wr_en       = r_wr_en;
    assign io_bus.wr_addr     = r_wr_addr;
    assign io_bus.wr_piece    = r_wr_piece;
    assign io_bus.busy        = r_busy;
    assign io_bus.move_ack    = r_ack;
    assign io_bus.move_reject = r_reject;
    assign io_bus.turn        = r_turn;
    assign io_bus.move_count  = r_count;

endmodule

// File: tb/tb_board_update_ctrl.sv
// Bench for board_update_ctrl: two instances driven identically, one with
// promotion and an 8-bit counter, one without promotion and a 2-bit counter.
// Expected board writes are queued as stimulus is driven and popped as the
// DUTs write.
module tb_board_update_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    board_update_ctrl_if #(.COUNT_WIDTH(8)) bus_a ();
    board_update_ctrl_if #(.COUNT_WIDTH(2)) bus_b ();

    board_update_ctrl #(.COUNT_WIDTH(8), .PROMOTE_EN(1)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus_a.slave)
    );

    board_update_ctrl #(.COUNT_WIDTH(2), .PROMOTE_EN(0)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ack_a    = 0;
    int rej_a    = 0;

    logic [9:0] qa[$];
    logic [9:0] qb[$];

    logic       exp_turn  = 1'b0;
    int         exp_cnt_a = 0;
    int         exp_cnt_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] opening(input int addr);
        logic [2:0] back [8];
        int row;
        int col;
        back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
        row  = addr / 8;
        col  = addr % 8;
        if (row == 0) return {1'b1, back[col]};
        if (row == 1) return 4'b1001;
        if (row == 6) return 4'b0001;
        if (row == 7) return {1'b0, back[col]};
        return 4'b0000;
    endfunction

    function automatic logic [3:0] exp_dst(input int to, input logic [3:0] pc, input bit prom);
        if (prom && pc[2:0] == 3'b001 && ((!pc[3] && to < 8) || (pc[3] && to >= 56)))
            return {pc[3], 3'b101};
        return pc;
    endfunction

    task automatic push_load();
        for (int a = 0; a < 64; a++) begin
            qa.push_back({6'(a), opening(a)});
            qb.push_back({6'(a), opening(a)});
        end
    endtask

    // Write scoreboard and pulse counters
    always @(negedge clk) begin
        logic [9:0] e;
        if (bus_a.wr_en) begin
            if (qa.size() == 0) chk("wr_a_extra", 1, 0);
            else begin e = qa.pop_front(); chk("wr_a", {bus_a.wr_addr, bus_a.wr_piece}, e); end
        end
        if (bus_b.wr_en) begin
            if (qb.size() == 0) chk("wr_b_extra", 1, 0);
            else begin e = qb.pop_front(); chk("wr_b", {bus_b.wr_addr, bus_b.wr_piece}, e); end
        end
        if (bus_a.move_ack)    ack_a++;
        if (bus_a.move_reject) rej_a++;
    end

    task automatic drive(input logic ng, input logic req, input logic [5:0] from,
                         input logic [5:0] to, input logic [3:0] pc);
        bus_a.new_game = ng;  bus_a.move_req = req;
        bus_a.move_from = from; bus_a.move_to = to; bus_a.move_piece = pc;
        bus_b.new_game = ng;  bus_b.move_req = req;
        bus_b.move_from = from; bus_b.move_to = to; bus_b.move_piece = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [5:0] from, input logic [5:0] to, input logic [3:0] pc);
        drive(1'b0, 1'b1, from, to, pc);
        tick();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 4'd0);
    endtask

    task automatic move_bad(input string tag, input logic [5:0] from, input logic [5:0] to,
                            input logic [3:0] pc);
        req(from, to, pc);
        chk({tag, "_reject"}, bus_a.move_reject, 1);
        chk({tag, "_wr_en"},  bus_a.wr_en, 0);
        chk({tag, "_turn"},   bus_a.turn, exp_turn);
        tick();
        chk({tag, "_reject_low"}, bus_a.move_reject, 0);
    endtask

    task automatic move_ok(input string tag, input logic [5:0] from, input logic [5:0] to,
                           input logic [3:0] pc, input bit overlap);
        qa.push_back({to, exp_dst(to, pc, 1'b1)});
        qb.push_back({to, exp_dst(to, pc, 1'b0)});
        qa.push_back({from, 4'b0000});
        qb.push_back({from, 4'b0000});
        req(from, to, pc);
        if (overlap) begin
            drive(1'b0, 1'b1, 6'd51, 6'd35, 4'b0001);
            tick();
            drive(1'b0, 1'b0, 6'd0, 6'd0, 4'd0);
            chk({tag, "_ovl_reject"}, bus_a.move_reject, 1);
            chk({tag, "_ovl_turn"},   bus_a.turn, exp_turn);
        end else begin
            tick();
        end
        chk({tag, "_dst_busy"}, bus_a.busy, 1);
        chk({tag, "_dst_wen"},  bus_a.wr_en, 1);
        tick();
        tick();
        exp_turn  = ~exp_turn;
        exp_cnt_a = exp_cnt_a + 1;
        exp_cnt_b = (exp_cnt_b == 3) ? 3 : exp_cnt_b + 1;
        chk({tag, "_ack"},   bus_a.move_ack, 1);
        chk({tag, "_busy"},  bus_a.busy, 0);
        chk({tag, "_wr_en"}, bus_a.wr_en, 0);
        chk({tag, "_turn"},  bus_a.turn, exp_turn);
        chk({tag, "_cnt_a"}, bus_a.move_count, exp_cnt_a);
        chk({tag, "_cnt_b"}, bus_b.move_count, exp_cnt_b);
        tick();
        chk({tag, "_ack_low"}, bus_a.move_ack, 0);
    endtask

    task automatic load_done(input string tag);
        repeat (64) tick();
        chk({tag, "_busy_last"}, bus_a.busy, 1);
        tick();
        chk({tag, "_busy"},  bus_a.busy, 0);
        chk({tag, "_wr_en"}, bus_a.wr_en, 0);
        chk({tag, "_turn"},  bus_a.turn, 0);
        chk({tag, "_cnt"},   bus_a.move_count, 0);
        chk({tag, "_qa"},    qa.size(), 0);
        chk({tag, "_qb"},    qb.size(), 0);
    endtask

    initial begin
        int a0;
        int r0;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 6'd0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_en",  bus_a.wr_en, 0);
        chk("rst_addr",   bus_a.wr_addr, 0);
        chk("rst_piece",  bus_a.wr_piece, 0);
        chk("rst_busy",   bus_a.busy, 1);
        chk("rst_ack",    bus_a.move_ack, 0);
        chk("rst_reject", bus_a.move_reject, 0);
        chk("rst_turn",   bus_a.turn, 0);
        chk("rst_cnt",    bus_a.move_count, 0);

        push_load();
        @(negedge clk) rst_n = 1'b1;
        load_done("load");

        move_bad("rej_color", 6'd12, 6'd28, 4'b1001);
        move_bad("rej_same",  6'd10, 6'd10, 4'b0001);
        move_bad("rej_none",  6'd50, 6'd42, 4'b0000);

        move_ok("mv_e2e4", 6'd52, 6'd36, 4'b0001, 1'b0);
        move_ok("mv_blk",  6'd12, 6'd28, 4'b1001, 1'b1);
        move_ok("mv_prom", 6'd8,  6'd0,  4'b0001, 1'b0);
        move_ok("mv_bn",   6'd1,  6'd18, 4'b1010, 1'b0);
        move_ok("mv_wn",   6'd62, 6'd45, 4'b0010, 1'b0);
        chk("sat_cnt_b", bus_b.move_count, 3);

        // NEW_GAME (with a coincident MOVE_REQ) while the destination write is out
        a0 = ack_a;
        qa.push_back({6'd27, 4'b1001});
        qb.push_back({6'd27, 4'b1001});
        req(6'd11, 6'd27, 4'b1001);
        tick();
        chk("ng_dst_wen", bus_a.wr_en, 1);
        r0 = rej_a;
        drive(1'b1, 1'b1, 6'd51, 6'd35, 4'b0001);
        tick();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 4'd0);
        chk("ng_wr_en", bus_a.wr_en, 0);
        chk("ng_busy",  bus_a.busy, 1);
        chk("ng_turn",  bus_a.turn, 0);
        chk("ng_cnt_a", bus_a.move_count, 0);
        chk("ng_cnt_b", bus_b.move_count, 0);
        push_load();
        load_done("ng_load");
        chk("ng_no_ack", ack_a, a0);
        chk("ng_no_rej", rej_a, r0);
        exp_turn = 1'b0;

        // Asynchronous reset in the middle of a load
        drive(1'b1, 1'b0, 6'd0, 6'd0, 4'd0);
        tick();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 4'd0);
        push_load();
        repeat (10) tick();
        chk("ml_wr_en_pre", bus_a.wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ml_rst_wr_en", bus_a.wr_en, 0);
        chk("ml_rst_busy",  bus_a.busy, 1);
        chk("ml_rst_addr",  bus_a.wr_addr, 0);
        qa.delete();
        qb.delete();
        push_load();
        @(negedge clk) rst_n = 1'b1;
        load_done("rl_load");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
